phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 The module SHALL provide parameter NUM_PHASES, default 5 (fetch, decode, execute, memory, writeback), number of stage phases per instruction, legal range 2..16.
REQ-002 The module SHALL provide parameter PHASE_CYCLES, default 1, clock cycles each phase is held, legal range 1..255.
REQ-003 The module SHALL provide parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-006 start  in  1  begin sequencing; sampled only in IDLE.
REQ-007 mode  in  2  sampled with start: 01 = RUN (continuous), 10 = STEP (one instruction), 00/11 = no-op.
REQ-008 stall  in  1  freeze the current phase this cycle.
REQ-009 flush  in  1  abandon the current instruction and restart at phase 0.
REQ-010 halt_req  in  1  finish the current instruction, then return to IDLE.
REQ-011 phase_en  out  NUM_PHASES  one-hot stage enable; bit i enables stage i.
REQ-012 instr_done  out  1  one-cycle pulse marking instruction completion.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 retired  out  CNT_W  count of completed instructions.

Function
REQ-015 FSM states SHALL be IDLE, RUN, STEP and DRAIN; state, phase_idx, dwell_cnt, halt-pending flag and retired SHALL be registered.
REQ-016 IDLE with start=1 and mode=01 SHALL go to RUN, with mode=10 to STEP; with mode 00/11 it SHALL stay in IDLE; phase_idx=0, dwell_cnt=0 on entry.
REQ-017 In RUN/STEP/DRAIN, phase_en SHALL equal (1 << phase_idx) gated by ~stall & ~flush (combinational gating of registered state); in IDLE phase_en SHALL be 0.
REQ-018 Latency: phase_en[0] SHALL first assert in the cycle after start is sampled.
REQ-019 Each phase SHALL be enabled for exactly PHASE_CYCLES non-stalled cycles: dwell_cnt counts 0..PHASE_CYCLES-1, then phase_idx advances and dwell_cnt returns to 0.
REQ-020 In the final non-stalled cycle of phase NUM_PHASES-1, instr_done SHALL pulse high, retired SHALL increment by 1 (wrapping mod 2^CNT_W) and phase_idx SHALL wrap to 0.
REQ-021 stall=1 (flush=0) SHALL hold phase_idx, dwell_cnt, state and retired unchanged and force phase_en=0 and instr_done=0.
REQ-022 flush=1 SHALL take priority over stall: phase_en=0, instr_done=0, retired unchanged, phase_idx and dwell_cnt cleared; RUN continues at phase 0 next cycle, STEP and DRAIN go to IDLE.
REQ-023 halt_req=1 in RUN SHALL move to DRAIN; DRAIN SHALL complete the current instruction and enter IDLE in the cycle after instr_done; halt_req in STEP/IDLE SHALL be ignored.
REQ-024 STEP SHALL enter IDLE in the cycle after its single instr_done.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 busy SHALL be high from the cycle after start is accepted through the cycle of the last phase_en of the instruction, and low in the following cycle.

Reset
REQ-027 reset=0 SHALL immediately, without a clock edge, force state=IDLE, phase_idx=0, dwell_cnt=0, halt-pending=0, phase_en=0, instr_done=0, busy=0, retired=0.
REQ-028 Reset asserted mid-instruction SHALL discard that instruction without incrementing retired; after release the block SHALL wait in IDLE for start.

Verification
REQ-029 Defaults, start with mode=01 -> phase_en 00001,00010,00100,01000,10000,00001,...; instr_done high on cycle 5 only; retired=1 after cycle 5, 2 after cycle 10.
REQ-030 PHASE_CYCLES=2, start with mode=01 -> each phase_en bit held 2 cycles; instr_done high on cycle 10; retired=1.
REQ-031 RUN, stall=1 for 3 cycles while phase_en=00100 -> phase_en=00000 for those 3 cycles, then 00100 for 1 cycle, then 01000; instr_done delayed by 3 cycles.
REQ-032 RUN, flush=1 and stall=1 together during phase 3 -> phase_en=00000 that cycle, 00001 next cycle; no instr_done; retired unchanged.
REQ-033 start with mode=10 -> exactly one 5-phase instruction, retired=1, busy low the cycle after instr_done; a start with mode=00 afterwards leaves busy=0 and phase_en=0.
REQ-034 RUN, halt_req pulsed during phase 1, then reset=0 asynchronously during phase 3 of a later RUN -> first instruction completes, busy drops; on reset all outputs read 0 before the next clock edge.

Source files
------------

// File: rtl/phase_sequencer_if.sv
// Control/status bundle for phase_sequencer: the sequencing requests going in,
// the stage enables and completion status coming out.
interface phase_sequencer_if #(
  parameter int NUM_PHASES = 5,
  parameter int CNT_W      = 32
);
  logic                  start;
  logic [1:0]            mode;
  logic                  stall;
  logic                  flush;
  logic                  halt_req;
  logic [NUM_PHASES-1:0] phase_en;
  logic                  instr_done;
  logic                  busy;
  logic [CNT_W-1:0]      retired;

  modport master (
    output start, mode, stall, flush, halt_req,
    input  phase_en, instr_done, busy, retired
  );

  modport slave (
    input  start, mode, stall, flush, halt_req,
    output phase_en, instr_done, busy, retired
  );
endinterface

// File: rtl/phase_sequencer.sv
// Multi-phase instruction sequencer: walks a one-hot stage enable through
// NUM_PHASES phases of PHASE_CYCLES cycles each, in continuous or single-step mode.
module phase_sequencer #(
  parameter int NUM_PHASES   = 5,
  parameter int PHASE_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  phase_sequencer_if.slave bus
);

  localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  localparam logic [1:0]    MODE_RUN   = 2'b01;
  localparam logic [1:0]    MODE_STEP  = 2'b10;
  localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_PHASES - 1);
  localparam logic [7:0]    LAST_DWELL = 8'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [PW-1:0]     phase_idx, phase_idx_n;
  logic [7:0]        dwell_cnt, dwell_cnt_n;
  logic              halt_pend, halt_pend_n;
  logic [CNT_W-1:0]  retired, retired_n;
  logic [NUM_PHASES-1:0] one_hot;
  logic [NUM_PHASES-1:0] phase_en;
  logic              instr_done;

  assign one_hot = {{(NUM_PHASES-1){1'b0}}, 1'b1} << phase_idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      phase_idx <= '0;
      dwell_cnt <= '0;
      halt_pend <= 1'b0;
      retired   <= '0;
    end else begin
      state     <= state_n;
      phase_idx <= phase_idx_n;
      dwell_cnt <= dwell_cnt_n;
      halt_pend <= halt_pend_n;
      retired   <= retired_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    phase_idx_n = phase_idx;
    dwell_cnt_n = dwell_cnt;
    halt_pend_n = halt_pend;
    retired_n   = retired;
    phase_en    = '0;
    instr_done  = 1'b0;

    if (state == S_IDLE) begin
      phase_idx_n = '0;
      dwell_cnt_n = '0;
      halt_pend_n = 1'b0;
      if (bus.start && bus.mode == MODE_RUN)  state_n = S_RUN;
      if (bus.start && bus.mode == MODE_STEP) state_n = S_STEP;
    end else begin
      // A halt seen while stalled or flushed is remembered until it can act.
      if (state == S_RUN && bus.halt_req) halt_pend_n = 1'b1;

      if (bus.flush) begin
        phase_idx_n = '0;
        dwell_cnt_n = '0;
        if (state != S_RUN) state_n = S_IDLE;
      end else if (!bus.stall) begin
        phase_en = one_hot;
        if (dwell_cnt == LAST_DWELL) begin
          dwell_cnt_n = '0;
          if (phase_idx == LAST_PHASE) begin
            instr_done  = 1'b1;
            retired_n   = retired + CNT_W'(1);
            phase_idx_n = '0;
          end else begin
            phase_idx_n = phase_idx + PW'(1);
          end
        end else begin
          dwell_cnt_n = dwell_cnt + 8'd1;
        end

        if (instr_done) begin
          state_n = (state == S_RUN && !halt_pend_n) ? S_RUN : S_IDLE;
        end else if (state == S_RUN && halt_pend_n) begin
          state_n = S_DRAIN;
        end
      end
    end
  end

  assign bus.phase_en   = phase_en;
  assign bus.instr_done = instr_done;
  assign bus.busy       = (state != S_IDLE);
  assign bus.retired    = retired;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a per-cycle vector table on the default
// configuration, plus sequences for async reset and two-cycle phases.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  phase_sequencer_if #(.NUM_PHASES(5), .CNT_W(32)) bus ();
  phase_sequencer_if #(.NUM_PHASES(5), .CNT_W(32)) bus2 ();

  phase_sequencer #(.NUM_PHASES(5), .PHASE_CYCLES(1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  phase_sequencer #(.NUM_PHASES(5), .PHASE_CYCLES(2), .CNT_W(32)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  typedef struct {
    logic        start;
    logic [1:0]  mode;
    logic        stall;
    logic        flush;
    logic        halt;
    logic [4:0]  pe;
    logic        done;
    logic        busy;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic st, input logic [1:0] md, input logic sl, input logic fl,
                     input logic hl, input logic [4:0] pe, input logic dn, input logic bz,
                     input logic [31:0] rt);
    vec_t v;
    v.start = st; v.mode = md; v.stall = sl; v.flush = fl; v.halt = hl;
    v.pe = pe; v.done = dn; v.busy = bz; v.ret = rt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic [1:0] md, input logic sl,
                       input logic fl, input logic hl);
    bus.start = st; bus.mode = md; bus.stall = sl; bus.flush = fl; bus.halt_req = hl;
  endtask

  task automatic check_all(input string tag, input logic [4:0] pe, input logic dn,
                           input logic bz, input logic [31:0] rt);
    check({tag, " phase_en"}, 32'(bus.phase_en), 32'(pe));
    check({tag, " instr_done"}, 32'(bus.instr_done), 32'(dn));
    check({tag, " busy"}, 32'(bus.busy), 32'(bz));
    check({tag, " retired"}, bus.retired, rt);
  endtask

  initial begin
    //  st  mode  stl fl  hlt  pe        done busy ret
    add(0, 2'b00, 0, 0, 0, 5'b00000, 0, 0, 0);   // idle after reset
    add(1, 2'b01, 0, 0, 0, 5'b00000, 0, 0, 0);   // start RUN sampled
    add(0, 2'b00, 0, 0, 0, 5'b00001, 0, 1, 0);
    add(1, 2'b10, 0, 0, 0, 5'b00010, 0, 1, 0);   // start while busy ignored
    add(0, 2'b00, 0, 0, 0, 5'b00100, 0, 1, 0);
    add(0, 2'b00, 0, 0, 0, 5'b01000, 0, 1, 0);
    add(0, 2'b00, 0, 0, 0, 5'b10000, 1, 1, 0);
    add(0, 2'b00, 0, 0, 0, 5'b00001, 0, 1, 1);
    add(0, 2'b00, 0, 0, 0, 5'b00010, 0, 1, 1);
    add(0, 2'b00, 1, 0, 0, 5'b00000, 0, 1, 1);   // stall x3 in phase 2
    add(0, 2'b00, 1, 0, 0, 5'b00000, 0, 1, 1);
    add(0, 2'b00, 1, 0, 0, 5'b00000, 0, 1, 1);
    add(0, 2'b00, 0, 0, 0, 5'b00100, 0, 1, 1);
    add(0, 2'b00, 0, 0, 0, 5'b01000, 0, 1, 1);
    add(0, 2'b00, 0, 0, 0, 5'b10000, 1, 1, 1);
    add(0, 2'b00, 0, 0, 0, 5'b00001, 0, 1, 2);
    add(0, 2'b00, 0, 0, 0, 5'b00010, 0, 1, 2);
    add(0, 2'b00, 0, 0, 0, 5'b00100, 0, 1, 2);
    add(0, 2'b00, 1, 1, 0, 5'b00000, 0, 1, 2);   // flush+stall in phase 3
    add(0, 2'b00, 0, 0, 0, 5'b00001, 0, 1, 2);
    add(0, 2'b00, 0, 0, 1, 5'b00010, 0, 1, 2);   // halt in phase 1
    add(0, 2'b00, 0, 0, 0, 5'b00100, 0, 1, 2);
    add(0, 2'b00, 0, 0, 0, 5'b01000, 0, 1, 2);
    add(0, 2'b00, 0, 0, 0, 5'b10000, 1, 1, 2);
    add(0, 2'b00, 0, 0, 0, 5'b00000, 0, 0, 3);   // drained to idle
    add(1, 2'b10, 0, 0, 0, 5'b00000, 0, 0, 3);   // start STEP
    add(0, 2'b00, 0, 0, 0, 5'b00001, 0, 1, 3);
    add(0, 2'b00, 0, 0, 1, 5'b00010, 0, 1, 3);   // halt ignored in STEP
    add(0, 2'b00, 0, 0, 0, 5'b00100, 0, 1, 3);
    add(0, 2'b00, 0, 0, 0, 5'b01000, 0, 1, 3);
    add(0, 2'b00, 0, 0, 0, 5'b10000, 1, 1, 3);
    add(0, 2'b00, 0, 0, 0, 5'b00000, 0, 0, 4);
    add(1, 2'b00, 0, 0, 0, 5'b00000, 0, 0, 4);   // mode 00 no-op
    add(0, 2'b00, 0, 0, 0, 5'b00000, 0, 0, 4);
    add(1, 2'b11, 0, 0, 0, 5'b00000, 0, 0, 4);   // mode 11 no-op
    add(0, 2'b00, 0, 0, 0, 5'b00000, 0, 0, 4);
    add(1, 2'b10, 0, 0, 0, 5'b00000, 0, 0, 4);   // STEP then flush
    add(0, 2'b00, 0, 0, 0, 5'b00001, 0, 1, 4);
    add(0, 2'b00, 0, 1, 0, 5'b00000, 0, 1, 4);
    add(0, 2'b00, 0, 0, 0, 5'b00000, 0, 0, 4);

    reset = 1'b0;
    drive(0, 2'b00, 0, 0, 0);
    bus2.start = 1'b0; bus2.mode = 2'b00; bus2.stall = 1'b0;
    bus2.flush = 1'b0; bus2.halt_req = 1'b0;
    #1;
    check_all("reset", 5'b00000, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].start, vecs[i].mode, vecs[i].stall, vecs[i].flush, vecs[i].halt);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].pe, vecs[i].done, vecs[i].busy, vecs[i].ret);
    end

    // Async reset in phase 3 of a fresh RUN instruction.
    @(negedge clk);
    drive(1, 2'b01, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(0, 2'b00, 0, 0, 0);
      #1;
      check($sformatf("rst_seq pe%0d", k), 32'(bus.phase_en), 32'(5'b00001 << k));
    end
    #2;
    reset = 1'b0;
    #1;
    check_all("async_rst", 5'b00000, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_all($sformatf("post_rst%0d", k), 5'b00000, 0, 0, 0);
    end
    @(negedge clk);
    drive(1, 2'b01, 0, 0, 0);
    @(negedge clk);
    drive(0, 2'b00, 0, 0, 0);
    #1;
    check_all("restart", 5'b00001, 0, 1, 0);

    // Two cycles per phase on the second instance.
    @(negedge clk);
    bus2.start = 1'b1; bus2.mode = 2'b01;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus2.start = 1'b0; bus2.mode = 2'b00;
      #1;
      check($sformatf("pc2 pe%0d", k), 32'(bus2.phase_en), 32'(5'b00001 << (k / 2)));
      check($sformatf("pc2 done%0d", k), 32'(bus2.instr_done), 32'(k == 9));
      check($sformatf("pc2 ret%0d", k), bus2.retired, 32'd0);
    end
    @(negedge clk);
    #1;
    check("pc2 ret_after", bus2.retired, 32'd1);
    check("pc2 pe_after", 32'(bus2.phase_en), 32'(5'b00001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
